// File: rtl/riscv_pkg.sv
// Shared load/store encodings and memory-FSM state type for the riscv core slice.
// Helpers here normalise funct3 sizes and detect misaligned accesses.
package riscv_pkg;

  typedef enum logic [2:0] {
    LDST_B  = 3'b000,
    LDST_H  = 3'b001,
    LDST_W  = 3'b010,
    LDST_BU = 3'b100,
    LDST_HU = 3'b101
  } ldst_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Reserved funct3 codes (011, 110, 111) behave as a full word access.
  function automatic ldst_size_t decode_size(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return LDST_B;
      3'b001:  return LDST_H;
      3'b100:  return LDST_BU;
      3'b101:  return LDST_HU;
      default: return LDST_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input ldst_size_t size, input logic [1:0] off);
    case (size)
      LDST_H, LDST_HU: return off[0];
      LDST_W:          return off != 2'b00;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_format.sv
// Combinational lane logic: store-data replication and byte enables, load align/extend.
// Store and load sides are independent so the fetch path can reuse either half.
module lsu_format
  import riscv_pkg::*;
(
  input  ldst_size_t  st_size,
  input  logic [1:0]  st_off,
  input  logic        st_we,
  input  logic [31:0] st_data,
  output logic [31:0] st_wd,
  output logic [3:0]  st_be,
  input  ldst_size_t  ld_size,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] lane;

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    st_wd = st_data;
    st_be = 4'b1111;
    case (st_size)
      LDST_B, LDST_BU: begin
        st_wd = {4{st_data[7:0]}};
        st_be = 4'b0001 << st_off;
      end
      LDST_H, LDST_HU: begin
        st_wd = {2{st_data[15:0]}};
        st_be = 4'b0011 << st_off;
      end
      default: ;
    endcase
    // Loads always fetch the whole word; only stores are byte-masked.
    if (!st_we) st_be = 4'b1111;
  end

  always_comb begin
    lane    = ld_word >> {ld_off, 3'b000};
    ld_data = lane;
    case (ld_size)
      LDST_B:  ld_data = {{24{lane[7]}}, lane[7:0]};
      LDST_BU: ld_data = {24'd0, lane[7:0]};
      LDST_H:  ld_data = {{16{lane[15]}}, lane[15:0]};
      LDST_HU: ld_data = {16'd0, lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller: issues one word-aligned memory access per core request,
// stalls the core for LATENCY cycles and formats the returned load data.
module data_mem_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned WRITE_POSTED = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misaligned_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       off_q;
  ldst_size_t       size_q;

  ldst_size_t  size_n;
  logic        mis;
  logic        idle_req;
  logic        accept;
  logic        posted;
  logic        start;
  logic [31:0] fmt_wd;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_rd;

  assign size_n   = decode_size(core_size_i);
  assign mis      = is_misaligned(size_n, core_addr_i[1:0]);
  assign idle_req = (state == IDLE) && core_req_i && !rst_i;
  assign accept   = idle_req && !mis;
  assign posted   = core_we_i && (WRITE_POSTED != 0);
  assign start    = accept && !posted;

  lsu_format u_fmt (
    .st_size (size_n),
    .st_off  (core_addr_i[1:0]),
    .st_we   (core_we_i),
    .st_data (core_wd_i),
    .st_wd   (fmt_wd),
    .st_be   (fmt_be),
    .ld_size (size_q),
    .ld_off  (off_q),
    .ld_word (mem_rd_i),
    .ld_data (fmt_rd)
  );

  // Memory-side outputs are zero unless a request is actually being issued.
  assign misaligned_o = idle_req && mis;
  assign mem_req_o    = accept;
  assign mem_we_o     = accept && core_we_i;
  assign mem_be_o     = accept ? fmt_be : 4'b0000;
  assign mem_addr_o   = accept ? {core_addr_i[31:2], 2'b00} : 32'd0;
  assign mem_wd_o     = (accept && core_we_i) ? fmt_wd : 32'd0;

  // Gated by rst_i so reset drops the stall asynchronously, even mid-WAIT.
  assign core_stall_o = !rst_i && (start || (state == WAIT));
  assign core_rd_o    = (state == DONE) ? fmt_rd : 32'd0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      off_q  <= 2'b00;
      size_q <= LDST_B;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            off_q  <= core_addr_i[1:0];
            size_q <= size_n;
            cnt    <= CNT_W'(LATENCY - 1);
            state  <= (LATENCY > 1) ? WAIT : DONE;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: three instances cover LATENCY 1/4/6 and posted stores.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [31:0] wd;

  logic        req1, req4, req6;
  logic [31:0] mrd1, mrd4, mrd6;
  logic [31:0] rd1, rd4, rd6;
  logic        stall1, stall4, stall6;
  logic        mis1, mis4, mis6;
  logic        mreq1, mreq4, mreq6;
  logic        mwe1, mwe4, mwe6;
  logic [3:0]  be1, be4, be6;
  logic [31:0] maddr1, maddr4, maddr6;
  logic [31:0] mwd1, mwd4, mwd6;

  int total = 0;
  int bad   = 0;
  int req_cnt1 = 0, req_cnt4 = 0, req_cnt6 = 0;
  int stall_cnt1 = 0, stall_cnt4 = 0, stall_cnt6 = 0;
  int base_req, base_stall, n;

  always #5 clk = ~clk;

  data_mem_ctrl #(.LATENCY(1), .WRITE_POSTED(0)) dut1 (
    .clk_i(clk), .rst_i(rst), .core_req_i(req1), .core_we_i(we), .core_size_i(size),
    .core_addr_i(addr), .core_wd_i(wd), .core_rd_o(rd1), .core_stall_o(stall1),
    .misaligned_o(mis1), .mem_req_o(mreq1), .mem_we_o(mwe1), .mem_be_o(be1),
    .mem_addr_o(maddr1), .mem_wd_o(mwd1), .mem_rd_i(mrd1));

  data_mem_ctrl #(.LATENCY(4), .WRITE_POSTED(1)) dut4 (
    .clk_i(clk), .rst_i(rst), .core_req_i(req4), .core_we_i(we), .core_size_i(size),
    .core_addr_i(addr), .core_wd_i(wd), .core_rd_o(rd4), .core_stall_o(stall4),
    .misaligned_o(mis4), .mem_req_o(mreq4), .mem_we_o(mwe4), .mem_be_o(be4),
    .mem_addr_o(maddr4), .mem_wd_o(mwd4), .mem_rd_i(mrd4));

  data_mem_ctrl #(.LATENCY(6), .WRITE_POSTED(0)) dut6 (
    .clk_i(clk), .rst_i(rst), .core_req_i(req6), .core_we_i(we), .core_size_i(size),
    .core_addr_i(addr), .core_wd_i(wd), .core_rd_o(rd6), .core_stall_o(stall6),
    .misaligned_o(mis6), .mem_req_o(mreq6), .mem_we_o(mwe6), .mem_be_o(be6),
    .mem_addr_o(maddr6), .mem_wd_o(mwd6), .mem_rd_i(mrd6));

  // Pre-edge values of request and stall give pulse and stall-cycle counts.
  always @(posedge clk) begin
    if (mreq1)  req_cnt1   <= req_cnt1 + 1;
    if (mreq4)  req_cnt4   <= req_cnt4 + 1;
    if (mreq6)  req_cnt6   <= req_cnt6 + 1;
    if (stall1) stall_cnt1 <= stall_cnt1 + 1;
    if (stall4) stall_cnt4 <= stall_cnt4 + 1;
    if (stall6) stall_cnt6 <= stall_cnt6 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic stall_of(input int which);
    case (which)
      1:       return stall1;
      4:       return stall4;
      default: return stall6;
    endcase
  endfunction

  // Edges until stall falls, bounded so a stuck stall still reaches the summary.
  task automatic cycles_to_done(input int which, output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (stall_of(which) && cnt < 20);
  endtask

  initial begin
    rst = 1'b1; req1 = 1'b1; req4 = 1'b0; req6 = 1'b0;
    we = 1'b0; size = 3'b010; addr = 32'h10; wd = 32'd0;
    mrd1 = 32'd0; mrd4 = 32'd0; mrd6 = 32'd0;
    #3;
    check("reset_stall_forced_low", {31'd0, stall1}, 32'd0);
    check("reset_mem_req", {31'd0, mreq1}, 32'd0);
    check("reset_misaligned", {31'd0, mis1}, 32'd0);
    check("reset_core_rd", rd1, 32'd0);
    check("reset_mem_be", {28'd0, be1}, 32'd0);
    req1 = 1'b0;
    @(negedge clk); rst = 1'b0;

    // LATENCY=1 LW 0x10
    @(negedge clk);
    req1 = 1'b1; we = 1'b0; size = 3'b010; addr = 32'h10; mrd1 = 32'hDEADBEEF;
    base_req = req_cnt1; base_stall = stall_cnt1;
    #1;
    check("lw1_stall_req_cycle", {31'd0, stall1}, 32'd1);
    check("lw1_mem_req", {31'd0, mreq1}, 32'd1);
    check("lw1_mem_addr", maddr1, 32'h10);
    check("lw1_mem_be", {28'd0, be1}, 32'hF);
    @(posedge clk); #1;
    check("lw1_done_stall", {31'd0, stall1}, 32'd0);
    check("lw1_done_rd", rd1, 32'hDEADBEEF);
    check("lw1_done_no_req", {31'd0, mreq1}, 32'd0);
    req1 = 1'b0;
    @(posedge clk); #1;
    check("lw1_idle_rd_zero", rd1, 32'd0);
    check("lw1_req_pulses", 32'(req_cnt1 - base_req), 32'd1);
    check("lw1_stall_cycles", 32'(stall_cnt1 - base_stall), 32'd1);

    // Non-posted SB 0x21 stalls one cycle on LATENCY=1
    @(negedge clk);
    req1 = 1'b1; we = 1'b1; size = 3'b000; addr = 32'h21; wd = 32'h0000_00AB;
    #1;
    check("sb1_be", {28'd0, be1}, 32'h2);
    check("sb1_wd", mwd1, 32'hABAB_ABAB);
    check("sb1_we", {31'd0, mwe1}, 32'd1);
    check("sb1_addr", maddr1, 32'h20);
    check("sb1_stall", {31'd0, stall1}, 32'd1);
    @(posedge clk); #1;
    check("sb1_done_stall", {31'd0, stall1}, 32'd0);
    req1 = 1'b0;
    @(posedge clk); #1;

    // LATENCY=4 LB 0x13, then LBU
    @(negedge clk);
    req4 = 1'b1; we = 1'b0; size = 3'b000; addr = 32'h13; mrd4 = 32'h80FF_0000;
    base_req = req_cnt4; base_stall = stall_cnt4;
    #1;
    check("lb4_be", {28'd0, be4}, 32'hF);
    cycles_to_done(4, n);
    check("lb4_edges_to_done", 32'(n), 32'd4);
    check("lb4_rd", rd4, 32'hFFFF_FF80);
    req4 = 1'b0;
    @(posedge clk); #1;
    check("lb4_stall_cycles", 32'(stall_cnt4 - base_stall), 32'd4);
    check("lb4_req_pulses", 32'(req_cnt4 - base_req), 32'd1);

    @(negedge clk);
    req4 = 1'b1; size = 3'b100; addr = 32'h13;
    cycles_to_done(4, n);
    check("lbu4_edges_to_done", 32'(n), 32'd4);
    check("lbu4_rd", rd4, 32'h0000_0080);
    req4 = 1'b0;
    @(posedge clk); #1;

    // Posted SH 0x22
    @(negedge clk);
    req4 = 1'b1; we = 1'b1; size = 3'b001; addr = 32'h22; wd = 32'h0000_1234;
    base_req = req_cnt4; base_stall = stall_cnt4;
    #1;
    check("sh4_stall", {31'd0, stall4}, 32'd0);
    check("sh4_be", {28'd0, be4}, 32'hC);
    check("sh4_wd", mwd4, 32'h1234_1234);
    check("sh4_addr", maddr4, 32'h20);
    check("sh4_we", {31'd0, mwe4}, 32'd1);
    @(posedge clk); #1;
    req4 = 1'b0;
    @(posedge clk); #1;
    check("sh4_stall_cycles", 32'(stall_cnt4 - base_stall), 32'd0);
    check("sh4_req_pulses", 32'(req_cnt4 - base_req), 32'd1);

    // Misaligned requests
    @(negedge clk);
    req1 = 1'b1; we = 1'b0; size = 3'b010; addr = 32'h05;
    base_req = req_cnt1;
    #1;
    check("lw_mis_flag", {31'd0, mis1}, 32'd1);
    check("lw_mis_no_req", {31'd0, mreq1}, 32'd0);
    check("lw_mis_no_stall", {31'd0, stall1}, 32'd0);
    @(posedge clk); #1;
    req1 = 1'b0;
    #1;
    check("lw_mis_pulse_ends", {31'd0, mis1}, 32'd0);
    check("lw_mis_req_count", 32'(req_cnt1 - base_req), 32'd0);

    @(negedge clk);
    req6 = 1'b1; size = 3'b001; addr = 32'h11;
    #1;
    check("lh_odd_mis", {31'd0, mis6}, 32'd1);
    size = 3'b011; addr = 32'h02;
    #1;
    check("unknown_size_as_w_mis", {31'd0, mis6}, 32'd1);
    size = 3'b101; addr = 32'h02;
    #1;
    check("lhu_even_ok", {31'd0, mis6}, 32'd0);
    req6 = 1'b0;

    // LATENCY=6 load with reset in its third stall cycle
    @(negedge clk);
    req6 = 1'b1; we = 1'b0; size = 3'b010; addr = 32'h40; mrd6 = 32'h1122_3344;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("l6_stall_before_reset", {31'd0, stall6}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("l6_reset_stall_drop", {31'd0, stall6}, 32'd0);
    check("l6_reset_rd_zero", rd6, 32'd0);
    req6 = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("l6_no_done_after_reset", rd6, 32'd0);
    check("l6_idle_after_reset", {31'd0, stall6}, 32'd0);

    @(negedge clk);
    req6 = 1'b1; addr = 32'h44;
    base_stall = stall_cnt6;
    cycles_to_done(6, n);
    check("l6_edges_to_done", 32'(n), 32'd6);
    check("l6_rd", rd6, 32'h1122_3344);
    req6 = 1'b0;
    @(posedge clk); #1;
    check("l6_stall_cycles", 32'(stall_cnt6 - base_stall), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
